turn_signal_seq: RTL and testbench
==================================

Name: turn_signal_seq

Overview:
Parametrised tail-light sequencer driving LAMPS lamps per side. Supports left and right sequential turn indication, hazard flashing and brake override. An internal prescaler advances the sequence once every DIV clocks, so the block runs directly from the board clock. It sits between the debounced switch inputs and the lamp/segment drivers.

Parameters:
LAMPS, 3, lamps per side (>=1); bit 0 is the innermost lamp.
DIV, 12500000, clock cycles per sequence step (>=1); DIV=1 steps every cycle.

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  synchronous, active-high reset
L  input  1  left turn request (level)
R  input  1  right turn request (level)
H  input  1  hazard request (level)
B  input  1  brake (level)
LLamp  output  LAMPS  left lamps, active-high
RLamp  output  LAMPS  right lamps, active-high
Mode  output  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD

Behaviour:
- Single clock domain (Clk); reset is synchronous and active-high (Rst).
- Registers: Mode (2b), Step (clog2(LAMPS+1) bits), prescaler Cnt (clog2(DIV) bits, min 1), BrakeQ (1b).
- Reset values: Mode=IDLE, Step=0, Cnt=0, BrakeQ=0, so LLamp=RLamp=0.
- Requested mode each cycle, by priority: H=1 or (L=1 and R=1) -> HAZARD; L only -> LEFT; R only -> RIGHT; none -> IDLE.
- Mode change: when the requested mode differs from Mode, at that edge:
  - Mode <= requested mode.
  - Step <= 0.
  - Cnt <= 0.
- Prescaler: otherwise Cnt increments. At Cnt==DIV-1, Cnt wraps to 0 and Tick=1 for that cycle.
- On Tick, Step advances:
  - LEFT/RIGHT: Step wraps LAMPS -> 0 (LAMPS+1 phases).
  - HAZARD: Step toggles 0/1.
  - IDLE: Step stays 0.
- BrakeQ <= B every cycle.
- Lamp outputs are decoded combinationally from registered Mode/Step/BrakeQ, so an input change is visible one cycle after the sampling edge.
- IDLE: both sides = {LAMPS{BrakeQ}}.
- LEFT: LLamp = thermometer of Step (Step lowest bits set: 0 -> all off, LAMPS -> all on). RLamp = {LAMPS{BrakeQ}}.
- RIGHT: mirror of LEFT.
- HAZARD: both sides = {LAMPS{Step[0]}}. Brake is ignored (hazard has priority). The first phase after entry is off.
- Each phase lasts exactly DIV cycles, except the first phase after a mode change, which also lasts exactly DIV cycles because Cnt is cleared.
- Request held constant: the sequence repeats indefinitely with no dropout cycle at wrap.
- Request toggles within a phase: the sequence restarts from Step 0 on every mode change. L then L+R enters HAZARD, and releasing R returns to LEFT at Step 0.
- Brake change: affects the non-sequencing side one cycle later. Step and Cnt are not disturbed.
- Rst mid-sequence: all registers return to reset values at that edge, regardless of inputs. Inputs are honoured from the next edge.
- No illegal Mode encoding exists. Step values above LAMPS are unreachable; if present they decode as Step=0 and wrap to 0 on the next Tick.

Test Plan:
- Reset: assert Rst 2 cycles with L=R=H=B=1 -> Mode=0, LLamp=RLamp=0 during reset.
- LAMPS=3, DIV=4, hold L=1 from edge 0 -> Mode=1 after edge 0. LLamp = 000 (4 clk), 001 (4), 011 (4), 111 (4), 000, ... RLamp=000 throughout.
- Same config, R=1, B=1 -> RLamp sequences 000/001/011/111 with 4 clk per phase. LLamp=111 one cycle after B rises, and 000 one cycle after B falls mid-sequence without disturbing the RLamp phase timing.
- L=1 for 6 cycles, then R also set -> Mode=3, both sides 000 for 4 clk, then 111/000 alternating every 4 clk. B=1 has no effect. Drop R -> Mode=1, LLamp restarts at 000.
- Rst pulsed while LLamp=011 -> next cycle Mode=0, outputs 0. With L still high -> Mode=1 one edge after Rst deasserts, Step=0.
- DIV=1, LAMPS=1, hold R -> RLamp toggles 0,1,0,1 every cycle. H=1 -> both sides 0,1,0,1 every cycle starting at 0.

Source files
------------

// File: rtl/turn_signal_seq.sv
// turn_signal_seq: tail-light sequencer with sequential turn, hazard and brake override, stepped by a DIV-cycle prescaler
module turn_signal_seq #(
  parameter int LAMPS = 3,
  parameter int DIV   = 12500000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             L,
  input  logic             R,
  input  logic             H,
  input  logic             B,
  output logic [LAMPS-1:0] LLamp,
  output logic [LAMPS-1:0] RLamp,
  output logic [1:0]       Mode
);
  localparam int SW = $clog2(LAMPS + 1);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} mode_t;
  mode_t            mode_q, req;
  logic [SW-1:0]    step_q, step_d;
  logic [CW-1:0]    cnt_q;
  logic             brake_q, tick;
  logic [LAMPS-1:0] therm;
  always_comb begin
    req    = (H || (L && R)) ? HAZARD : L ? LEFT : R ? RIGHT : IDLE;
    tick   = cnt_q == CW'(DIV - 1);
    // out-of-range steps decode dark and fall back to 0 on the next tick
    step_d = mode_q == HAZARD ? SW'(step_q == '0) :
             (mode_q == IDLE || step_q >= SW'(LAMPS)) ? '0 : step_q + SW'(1);
    for (int i = 0; i < LAMPS; i++) therm[i] = step_q > SW'(i) && step_q <= SW'(LAMPS);
    LLamp  = mode_q == HAZARD ? {LAMPS{step_q == SW'(1)}} : mode_q == LEFT  ? therm : {LAMPS{brake_q}};
    RLamp  = mode_q == HAZARD ? {LAMPS{step_q == SW'(1)}} : mode_q == RIGHT ? therm : {LAMPS{brake_q}};
    Mode   = mode_q;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mode_q  <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      brake_q <= 1'b0;
    end else begin
      brake_q <= B;
      if (req != mode_q) begin
        mode_q <= req;
        step_q <= '0;
        cnt_q  <= '0;
      end else begin
        cnt_q <= tick ? '0 : cnt_q + CW'(1);
        if (tick) step_q <= step_d;
      end
    end
  end
endmodule

// File: tb/tb_turn_signal_seq.sv
// tb_turn_signal_seq: scoreboard bench driving two configurations (3 lamps/DIV 4 and 1 lamp/DIV 1) with shared stimulus
module tb_turn_signal_seq;
  logic clk = 1'b0, rst = 1'b0, l = 1'b0, r = 1'b0, h = 1'b0, b = 1'b0;
  logic [2:0] ll3, rl3;
  logic [0:0] ll1, rl1;
  logic [1:0] m3, m1;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic [1:0] m;
    logic [2:0] l3, r3;
    logic       l1, r1;
  } exp_t;
  exp_t q[$];

  int mdl_m = 0, mdl_k = 0;
  bit mdl_bq = 0;

  always #5 clk = ~clk;

  turn_signal_seq #(.LAMPS(3), .DIV(4)) dut_a (
    .Clk(clk), .Rst(rst), .L(l), .R(r), .H(h), .B(b),
    .LLamp(ll3), .RLamp(rl3), .Mode(m3));
  turn_signal_seq #(.LAMPS(1), .DIV(1)) dut_b (
    .Clk(clk), .Rst(rst), .L(l), .R(r), .H(h), .B(b),
    .LLamp(ll1), .RLamp(rl1), .Mode(m1));

  // lamp pattern of one side, from time spent in the current mode
  function automatic logic [2:0] side(int n, int dv, int m, int k, bit bq, bit left);
    int per = (m == 1 || m == 2) ? n + 1 : (m == 3) ? 2 : 1;
    int s = (k / dv) % per;
    int all = (1 << n) - 1;
    if (m == 3) return (s == 1) ? 3'(all) : 3'd0;
    if ((left && m == 1) || (!left && m == 2)) return 3'((1 << s) - 1);
    return bq ? 3'(all) : 3'd0;
  endfunction

  task automatic cyc(bit rs, bit il, bit ir, bit ih, bit ib);
    int req;
    exp_t e;
    @(negedge clk);
    rst = rs; l = il; r = ir; h = ih; b = ib;
    req = (ih || (il && ir)) ? 3 : il ? 1 : ir ? 2 : 0;
    if (rs) begin
      mdl_m = 0; mdl_k = 0; mdl_bq = 0;
    end else begin
      if (req != mdl_m) begin mdl_m = req; mdl_k = 0; end
      else mdl_k++;
      mdl_bq = ib;
    end
    e.m  = 2'(mdl_m);
    e.l3 = side(3, 4, mdl_m, mdl_k, mdl_bq, 1);
    e.r3 = side(3, 4, mdl_m, mdl_k, mdl_bq, 0);
    e.l1 = side(1, 1, mdl_m, mdl_k, mdl_bq, 1) != 0;
    e.r1 = side(1, 1, mdl_m, mdl_k, mdl_bq, 0) != 0;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (m3 !== e.m || ll3 !== e.l3 || rl3 !== e.r3 || m1 !== e.m || ll1 !== e.l1 || rl1 !== e.r1) begin
        failures++;
        $display("FAIL lamps t=%0t got mode=%0d/%0d L3=%b R3=%b L1=%b R1=%b need mode=%0d L3=%b R3=%b L1=%b R1=%b",
                 $time, m3, m1, ll3, rl3, ll1, rl1, e.m, e.l3, e.r3, e.l1, e.r1);
      end
    end
  end

  initial begin
    repeat (2) cyc(1, 1, 1, 1, 1);
    repeat (20) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 24; i++) cyc(0, 0, 1, 0, i >= 5 && i < 14);
    repeat (6) cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 1, 0, i > 7);
    repeat (9) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    repeat (6) cyc(0, 1, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 1, 1);
    repeat (4) cyc(0, 0, 0, 0, 1);
    begin
      bit rl = 0, rr = 0, rh = 0, rb = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(15) == 0) rl = ~rl;
        if ($urandom_range(15) == 0) rr = ~rr;
        if ($urandom_range(40) == 0) rh = ~rh;
        if ($urandom_range(7) == 0) rb = ~rb;
        cyc($urandom_range(250) == 0, rl, rr, rh, rb);
      end
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d need=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
